// File: rtl/cla_serial_adder.sv
// Serial adder built around one SLICE-bit carry-lookahead slice.
// An accepted operand pair is added SLICE bits per cycle, least significant
// slice first, over N = WIDTH/SLICE cycles. The block also accumulates the
// word-level group propagate/generate terms. Results are held until they
// are consumed with a valid/ready handshake.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand set
// RUN   | one slice added per cycle, idx_q selects the slice
// DONE  | out_valid=1, result held until out_ready=1
module cla_serial_adder #(
  parameter int WIDTH = 12,
  parameter int SLICE = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_p,
  output logic             out_g
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic             p_q;
  logic             g_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // Current slice: the operand registers are shifted right each RUN cycle,
  // so the active slice always sits in the low SLICE bits.
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] sp;
  logic [SLICE-1:0] sg;
  logic [SLICE-1:0] ss;
  logic [SLICE:0]   sc;
  logic             pg;
  logic             gg;

  // Carry-lookahead slice plus carry-independent group terms, and the
  // merge of the slice sum into its position of the result word.
  always_comb begin
    sa    = a_q[SLICE-1:0];
    sb    = b_q[SLICE-1:0];
    sp    = '0;
    sg    = '0;
    ss    = '0;
    sc    = '0;
    sc[0] = carry_q;
    gg    = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      sp[i]   = sa[i] | sb[i];
      sg[i]   = sa[i] & sb[i];
      ss[i]   = sa[i] ^ sb[i] ^ sc[i];
      sc[i+1] = (sc[i] & sp[i]) | sg[i];
      gg      = (gg & sp[i]) | sg[i];
    end
    pg    = &sp;
    sum_d = sum_q;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDXW'(k)) begin
        sum_d[k*SLICE +: SLICE] = ss;
      end
    end
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      p_q         <= 1'b0;
      g_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            carry_q    <= in_carry;
            p_q        <= 1'b1;
            g_q        <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= sc[SLICE];
          p_q     <= p_q & pg;
          g_q     <= (g_q & pg) | gg;
          a_q     <= a_q >> SLICE;
          b_q     <= b_q >> SLICE;
          idx_q   <= idx_q + IDXW'(1);
          if (idx_q == LAST_IDX) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // No capture here: the next operand set is taken from IDLE only.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_carry = carry_q;
  assign out_p     = p_q;
  assign out_g     = g_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Scoreboard bench for cla_serial_adder (WIDTH=12, SLICE=3).
// The acceptance tracker predicts handshakes from its own idle/busy model
// and pushes arithmetic expectations; the output monitor pops and compares.
module tb_cla_serial_adder;

  localparam int WIDTH = 12;
  localparam int SLICE = 3;
  localparam int N     = WIDTH / SLICE;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             p;
    logic             g;
    int               acc_cyc;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_p;
  logic             out_g;

  cla_serial_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clock    (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_carry (in_carry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_carry(out_carry),
    .out_p    (out_p),
    .out_g    (out_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  logic exp_idle = 1'b1;
  logic seen     = 1'b0;
  logic [WIDTH-1:0] held_sum;
  logic held_co, held_p, held_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the whole word.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input int acc);
    exp_t e;
    logic [WIDTH:0] full;
    logic [WIDTH:0] ab;
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    ab   = {1'b0, a} + {1'b0, b};
    e.sum     = full[WIDTH-1:0];
    e.co      = full[WIDTH];
    e.p       = &(a | b);
    e.g       = ab[WIDTH];
    e.acc_cyc = acc;
    return e;
  endfunction

  // Acceptance tracker: runs mid-cycle before the rising edge, when inputs
  // and DUT outputs are both settled; predicts what the coming edge does.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      exp_q.delete();
      exp_idle = 1'b1;
    end else if (exp_idle && in_valid) begin
      exp_q.push_back(model(in_a, in_b, in_carry, cyc));
      exp_idle = 1'b0;
    end else if (!exp_idle && out_valid && out_ready) begin
      exp_idle = 1'b1;
    end
    cyc++;
  end

  // Output monitor.
  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_sum", {20'd0, out_sum}, 32'd0);
      check("rst_out_carry", {31'd0, out_carry}, 32'd0);
      check("rst_out_p", {31'd0, out_p}, 32'd0);
      check("rst_out_g", {31'd0, out_g}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_idle});
      if (out_valid && !seen) begin
        seen = 1'b1;
        held_sum = out_sum;
        held_co  = out_carry;
        held_p   = out_p;
        held_g   = out_g;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_sum", {20'd0, out_sum}, {20'd0, e.sum});
          check("out_carry", {31'd0, out_carry}, {31'd0, e.co});
          check("out_p", {31'd0, out_p}, {31'd0, e.p});
          check("out_g", {31'd0, out_g}, {31'd0, e.g});
          check("latency", cyc - e.acc_cyc - 1, N);
          done_cnt++;
        end
      end else if (out_valid && seen) begin
        check("hold_sum", {20'd0, out_sum}, {20'd0, held_sum});
        check("hold_carry", {31'd0, out_carry}, {31'd0, held_co});
        check("hold_p", {31'd0, out_p}, {31'd0, held_p});
        check("hold_g", {31'd0, out_g}, {31'd0, held_g});
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      tick();
      n++;
    end
    if (done_cnt < target) check("result_timeout", done_cnt, target);
  endtask

  // One operand set offered for a single cycle while the block is idle.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_carry = c;
    tick();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_carry = 1'b0;
  endtask

  initial begin
    int target;
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_carry  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Directed corner vectors.
    issue(12'hFFF, 12'h001, 1'b0);
    wait_done(1);
    tick();
    issue(12'h123, 12'h456, 1'b1);
    wait_done(2);
    tick();
    issue(12'h800, 12'h800, 1'b1);
    wait_done(3);
    tick();

    // Consumer stalls for three DONE cycles.
    out_ready = 1'b0;
    issue(12'hABC, 12'h321, 1'b0);
    wait_done(4);
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset while the third slice is in progress.
    issue(12'h5A5, 12'h3C3, 1'b1);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    issue(12'h0AA, 12'h055, 1'b0);
    wait_done(5);
    tick();

    // in_valid held high with fresh random data every cycle.
    target = done_cnt + 1000;
    n = 0;
    while (done_cnt < target && n < 30000) begin
      int sel;
      sel       = $urandom_range(0, 7);
      in_valid  = 1'b1;
      in_a      = (sel == 0) ? '1 : (sel == 1) ? '0 : WIDTH'($urandom);
      in_b      = (sel == 2) ? '1 : (sel == 1) ? '0 : WIDTH'($urandom);
      in_carry  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    if (done_cnt < target) check("random_timeout", done_cnt, target);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_serial_adder.md
CLA_SERIAL_ADDER -- requirements
Module: cla_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 12: operand width in bits.
REQ-002 SHALL have parameter SLICE, default 3: bits added per cycle by the internal carry-lookahead slice.
REQ-003 SHALL have WIDTH as a nonzero multiple of SLICE; N = WIDTH/SLICE is the number of slice passes.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 in_a  input  WIDTH  operand A.
REQ-009 in_b  input  WIDTH  operand B.
REQ-010 in_carry  input  1  carry-in.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_sum  output  WIDTH  low WIDTH bits of in_a + in_b + in_carry.
REQ-014 out_carry  output  1  carry-out of that sum.
REQ-015 out_p  output  1  word group propagate.
REQ-016 out_g  output  1  word group generate.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 SHALL assert in_ready only in IDLE; no new operands are accepted in RUN or DONE.
REQ-019 SHALL, on an edge with in_valid=1 and in_ready=1, capture in_a, in_b and in_carry, clear the slice index to 0, and enter RUN.
REQ-020 SHALL, in each RUN cycle k (0..N-1), add bits [k*SLICE +: SLICE] of A and B plus the carry register through one SLICE-bit carry-lookahead slice.
REQ-021 SHALL use per-bit p = a|b, g = a&b and s = a^b^c in the slice, with carry lookahead c[i+1] = c[i]&p[i] | g[i] and c[0] = the carry register.
REQ-022 SHALL, at the end of each RUN cycle k, write the slice sum into out_sum bits [k*SLICE +: SLICE] and load the slice carry-out into the carry register.
REQ-023 SHALL accumulate group propagate as P = P & pg_k, with P initialised to 1 at capture.
REQ-024 SHALL accumulate group generate as G = G & pg_k | gg_k, with G initialised to 0 at capture.
REQ-025 SHALL compute the slice pg_k and gg_k terms in REQ-023 and REQ-024 independently of the carry.
REQ-026 SHALL move from RUN to DONE on the edge that completes slice N-1; out_valid is therefore 1 exactly N cycles after the acceptance edge.
REQ-027 SHALL, in DONE, hold out_valid=1 with out_sum, out_carry, out_p and out_g stable until out_ready=1.
REQ-028 SHALL return to IDLE on the edge where out_valid=1 and out_ready=1.
REQ-029 SHALL NOT accept new operands on the DONE->IDLE edge itself; the earliest next acceptance is the following edge, giving a minimum initiation interval of N+2 cycles.
REQ-030 SHALL ignore out_ready outside DONE, and ignore in_valid and input data outside IDLE.
REQ-031 SHALL drive out_carry from the final carry register, out_p from P and out_g from G.
REQ-032 SHALL, when N=1, complete in a single RUN cycle.
REQ-033 SHALL wrap the sum modulo 2^WIDTH, with the overflow bit reported only on out_carry.

Reset
REQ-034 SHALL, while reset=1 and regardless of clock, force state to IDLE.
REQ-035 SHALL, while reset=1, force out_valid=0, out_sum=0, out_carry=0, out_p=0 and out_g=0, with in_ready=1.
REQ-036 SHALL discard an in-flight operation (RUN or DONE) on reset with no partial result emitted; the first acceptance is possible on the first edge after reset deasserts.

Verification
REQ-037 SHALL verify: WIDTH=12, SLICE=3; in_a=0xFFF, in_b=0x001, in_carry=0 -> out_valid 4 cycles after acceptance, out_sum=0x000, out_carry=1, out_p=1, out_g=1.
REQ-038 SHALL verify: in_a=0x123, in_b=0x456, in_carry=1 -> out_sum=0x57A, out_carry=0, out_p=0, out_g=0.
REQ-039 SHALL verify: in_a=0x800, in_b=0x800, in_carry=1 -> out_sum=0x001, out_carry=1, out_p=0, out_g=1.
REQ-040 SHALL verify: out_ready held 0 for 3 cycles in DONE -> outputs stable and in_ready=0 throughout; after out_ready=1, in_ready=1 on the next cycle.
REQ-041 SHALL verify: reset asserted in RUN at slice 2 -> out_valid never rises and all outputs are 0; a post-reset operation on 0x0AA + 0x055 gives out_sum=0x0FF, out_carry=0.
REQ-042 SHALL verify: in_valid held 1 continuously with changing data -> only operands present on IDLE edges are captured, and every result matches a reference model for 1000 random vectors.
